filt_win_stats: RTL and testbench
=================================

FILT_WIN_STATS -- requirements
Module: filt_win_stats

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the sample width in bits.
REQ-002 The block SHALL have parameter WIN_LOG2, default 3, giving log2 of the window length; window N = 2^WIN_LOG2; legal range 1..6.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port i_vld, input, 1 bit: i_data holds a valid filtered sample this cycle (no input backpressure).
REQ-006 The block SHALL have port i_data, input, DW bits: unsigned filtered sample from the upstream IIR stage.
REQ-007 The block SHALL have port i_clr, input, 1 bit: synchronous abort of the window in progress.
REQ-008 The block SHALL have port o_ready, input, 1 bit: downstream accepts the result.
REQ-009 The block SHALL have port o_vld, output, 1 bit: result registers hold an unconsumed window result.
REQ-010 The block SHALL have ports o_min, o_max and o_mean, outputs, DW bits each: window minimum, maximum and truncated mean.
REQ-011 The block SHALL have port o_drop, output, 1 bit: one-cycle pulse when a completed window result is discarded.

Function
REQ-012 The FSM SHALL have two states: EMPTY (no samples in window) and FILL (1..N-1 samples held).
REQ-013 In EMPTY, an i_vld sample SHALL load min=max=sum=i_data, set cnt=1 and move to FILL (or complete immediately if N=1 is ever allowed; N>=2 by REQ-002).
REQ-014 In FILL, each i_vld sample SHALL update min=min(min,x), max=max(max,x), sum+=x and cnt+=1.
REQ-015 The accumulator sum SHALL be DW+WIN_LOG2 bits wide and SHALL NOT overflow for any input sequence.
REQ-016 The sample that makes cnt reach N SHALL complete the window: the result uses that sample, and the FSM returns to EMPTY in the same edge.
REQ-017 Cycles with i_vld=0 SHALL leave all window state unchanged; samples need not be contiguous.
REQ-018 The mean SHALL be computed as final sum >> WIN_LOG2 (truncation, no rounding).
REQ-019 Latency: the result SHALL appear on the outputs, with o_vld=1, on the cycle after the clock edge that samples the completing input.
REQ-020 A handshake SHALL occur on any cycle with o_vld=1 and o_ready=1; o_vld SHALL fall on the next edge unless a new result loads on that same edge.
REQ-021 While o_vld=1 and no handshake occurs, o_min, o_max and o_mean SHALL remain stable.
REQ-022 Accumulation of the next window SHALL continue independently of o_vld/o_ready.
REQ-023 If a window completes while o_vld=1 and o_ready=0, the new result SHALL be discarded and o_drop SHALL pulse high for one cycle, with the held result kept.
REQ-024 If a window completes in the same cycle as a handshake, the new result SHALL load, o_vld SHALL stay 1, and there SHALL be no drop.
REQ-025 i_clr=1 SHALL return the FSM to EMPTY with cnt=0 and discard any i_vld sample in the same cycle; a window completing in that cycle SHALL NOT produce a result.
REQ-026 i_clr SHALL NOT affect the result registers, o_vld or handshakes.
REQ-027 o_ready SHALL be ignored while o_vld=0.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL set the FSM to EMPTY, cnt, sum, min and max to 0, o_vld=0, o_min=o_max=o_mean=0 and o_drop=0.
REQ-029 Reset SHALL override i_clr, i_vld and o_ready.
REQ-030 Reset mid-window SHALL discard the partial window, and a pending unconsumed result SHALL be lost.
REQ-031 The first window after reset release SHALL start with the first i_vld sample.

Verification
REQ-032 With N=8, o_ready=1, feeding 0,1,..,7 on consecutive cycles SHALL give o_min=0, o_max=7, o_mean=3 and o_vld high for exactly 1 cycle, 1 cycle after the sample 7 edge.
REQ-033 Feeding eight samples of 255 with gaps of 0-3 idle cycles SHALL give min=max=mean=255 with no sum overflow.
REQ-034 With o_ready=0, after two windows (10,20,..,80 then 1..8), the outputs SHALL hold min=10, max=80 and mean=45, and o_drop SHALL pulse on the second completion.
REQ-035 When the second window completes on the same cycle that o_ready=1, the outputs SHALL switch to min=1, max=8 and mean=4 (36>>3), o_vld SHALL stay 1 and o_drop SHALL stay 0.
REQ-036 Asserting i_clr after 5 samples, then feeding 8 samples of 100, SHALL give exactly one result of min=max=mean=100.
REQ-037 Asserting rst_n=0 for one cycle after 4 samples with a pending result SHALL give o_vld=0 and outputs 0, and the next 8 samples SHALL produce a correct fresh result.

Source files
------------

// File: rtl/filt_win_stats.sv
// rtl/filt_win_stats.sv - windowed min/max/mean statistics over N = 2**WIN_LOG2 filtered samples
module filt_win_stats #(
    parameter int DW       = 8,
    parameter int WIN_LOG2 = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    input  logic [DW-1:0] i_data,
    input  logic          i_clr,
    input  logic          o_ready,
    output logic          o_vld,
    output logic [DW-1:0] o_min,
    output logic [DW-1:0] o_max,
    output logic [DW-1:0] o_mean,
    output logic          o_drop
);

    localparam int SW = DW + WIN_LOG2;

    typedef enum logic {EMPTY, FILL} state_t;

    state_t              state_q;
    logic [WIN_LOG2-1:0] cnt_q;
    logic [SW-1:0]       sum_q;
    logic [DW-1:0]       min_q, max_q;
    logic                o_vld_q, o_drop_q;
    logic [DW-1:0]       o_min_q, o_max_q, o_mean_q;

    logic [DW-1:0]       min_d, max_d;
    logic [SW-1:0]       sum_d, mean_full;
    logic                take, complete, handshake;

    // Window state as it would stand after absorbing the current sample.
    always_comb begin
        min_d = i_data;
        max_d = i_data;
        sum_d = SW'(i_data);
        if (state_q == FILL) begin
            min_d = (i_data < min_q) ? i_data : min_q;
            max_d = (i_data > max_q) ? i_data : max_q;
            sum_d = sum_q + SW'(i_data);
        end
        mean_full = sum_d >> WIN_LOG2;
        take      = i_vld && !i_clr;
        complete  = take && (state_q == FILL) && (cnt_q == {WIN_LOG2{1'b1}});
        handshake = o_vld_q && o_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            cnt_q    <= '0;
            sum_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            o_vld_q  <= 1'b0;
            o_drop_q <= 1'b0;
            o_min_q  <= '0;
            o_max_q  <= '0;
            o_mean_q <= '0;
        end else begin
            o_drop_q <= 1'b0;

            if (i_clr || complete) begin
                state_q <= EMPTY;
                cnt_q   <= '0;
                sum_q   <= '0;
                min_q   <= '0;
                max_q   <= '0;
            end else if (take) begin
                state_q <= FILL;
                cnt_q   <= cnt_q + WIN_LOG2'(1);
                sum_q   <= sum_d;
                min_q   <= min_d;
                max_q   <= max_d;
            end

            // A fresh result may replace the held one only when it is free or consumed this edge.
            if (complete) begin
                if (!o_vld_q || o_ready) begin
                    o_vld_q  <= 1'b1;
                    o_min_q  <= min_d;
                    o_max_q  <= max_d;
                    o_mean_q <= mean_full[DW-1:0];
                end else begin
                    o_drop_q <= 1'b1;
                end
            end else if (handshake) begin
                o_vld_q <= 1'b0;
            end
        end
    end

    assign o_vld  = o_vld_q;
    assign o_drop = o_drop_q;
    assign o_min  = o_min_q;
    assign o_max  = o_max_q;
    assign o_mean = o_mean_q;

endmodule

// File: tb/tb_filt_win_stats.sv
// tb/tb_filt_win_stats.sv - directed self-checking bench for filt_win_stats
module tb_filt_win_stats;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_vld;
    logic [7:0] i_data;
    logic       i_clr;
    logic       o_ready;
    logic       o_vld;
    logic [7:0] o_min, o_max, o_mean;
    logic       o_drop;

    int checks = 0;
    int errors = 0;
    int vld_seen;

    filt_win_stats #(.DW(8), .WIN_LOG2(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (i_vld),
        .i_data  (i_data),
        .i_clr   (i_clr),
        .o_ready (o_ready),
        .o_vld   (o_vld),
        .o_min   (o_min),
        .o_max   (o_max),
        .o_mean  (o_mean),
        .o_drop  (o_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] x);
        i_vld  = 1'b1;
        i_data = x;
        step();
        i_vld  = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] mean);
        check({tag, "_vld"}, o_vld, 1);
        check({tag, "_min"}, o_min, mn);
        check({tag, "_max"}, o_max, mx);
        check({tag, "_mean"}, o_mean, mean);
    endtask

    initial begin
        rst_n = 1'b0; i_vld = 1'b0; i_data = '0; i_clr = 1'b0; o_ready = 1'b0;
        repeat (3) step();
        check("rst_vld", o_vld, 0);
        check("rst_min", o_min, 0);
        check("rst_max", o_max, 0);
        check("rst_mean", o_mean, 0);
        check("rst_drop", o_drop, 0);
        rst_n = 1'b1;
        step();

        // Contiguous 0..7 with the consumer always ready.
        o_ready = 1'b1;
        for (int i = 0; i < 7; i++) drive(8'(i));
        check("ramp_early_vld", o_vld, 0);
        drive(8'd7);
        check_res("ramp", 8'd0, 8'd7, 8'd3);
        step();
        check("ramp_vld_fall", o_vld, 0);

        // Full-scale samples with idle gaps: sum reaches 2040 without wrapping.
        for (int i = 0; i < 8; i++) begin
            drive(8'd255);
            if (i < 7) repeat (i % 4) step();
        end
        check_res("full", 8'd255, 8'd255, 8'd255);
        step();
        check("full_vld_fall", o_vld, 0);

        // Stalled consumer: second window is dropped, first is held.
        o_ready = 1'b0;
        for (int i = 1; i <= 8; i++) drive(8'(i * 10));
        check_res("hold1", 8'd10, 8'd80, 8'd45);
        check("hold1_drop", o_drop, 0);
        for (int i = 1; i <= 8; i++) drive(8'(i));
        check_res("hold2", 8'd10, 8'd80, 8'd45);
        check("hold2_drop", o_drop, 1);
        step();
        check("drop_pulse_end", o_drop, 0);
        check("hold_still_vld", o_vld, 1);

        // Completion coinciding with a handshake replaces the held result.
        for (int i = 1; i <= 7; i++) drive(8'(i));
        o_ready = 1'b1;
        drive(8'd8);
        check_res("swap", 8'd1, 8'd8, 8'd4);
        check("swap_drop", o_drop, 0);
        step();
        check("swap_vld_fall", o_vld, 0);

        // Clear mid-window, and clear on the would-be completing sample.
        vld_seen = 0;
        for (int i = 0; i < 5; i++) drive(8'd7);
        i_clr = 1'b1;
        drive(8'd0);
        i_clr = 1'b0;
        for (int i = 0; i < 7; i++) drive(8'd50);
        i_clr = 1'b1;
        drive(8'd50);
        i_clr = 1'b0;
        check("clr_complete_none", o_vld, 0);
        for (int i = 0; i < 8; i++) begin
            drive(8'd100);
            if (o_vld) vld_seen++;
        end
        check_res("clr", 8'd100, 8'd100, 8'd100);
        step();
        check("clr_results", vld_seen, 1);

        // Reset with a pending result and a partial window.
        o_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive(8'd9);
        check("pend_vld", o_vld, 1);
        for (int i = 0; i < 4; i++) drive(8'd3);
        rst_n = 1'b0;
        o_ready = 1'b1;
        i_clr = 1'b1;
        drive(8'd200);
        i_clr = 1'b0;
        check("mid_rst_vld", o_vld, 0);
        check("mid_rst_min", o_min, 0);
        check("mid_rst_max", o_max, 0);
        check("mid_rst_mean", o_mean, 0);
        check("mid_rst_drop", o_drop, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) drive(8'(2 * i));
        check("fresh_early_vld", o_vld, 0);
        drive(8'd16);
        check_res("fresh", 8'd2, 8'd16, 8'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
